// File: rtl/collision_pkg.sv
// Shared widths, scan states and the lowest-set-bit helper for the collision scanner.
package collision_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [15:0] mask);
        logic [IDX_W-1:0] idx;
        idx = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (mask[k]) begin
                idx = IDX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/collision_overlap.sv
// Combinational half-open box overlap between the frog and one car,
// including the optional wrapped segment of a car that runs off the right edge.
module collision_overlap
    import collision_pkg::*;
#(
    parameter int FROG_W    = 32,
    parameter int CAR_W     = 32,
    parameter int TILE_SIZE = 32,
    parameter int SCREEN_W  = 640,
    parameter int WRAP_EN   = 1
) (
    input  logic [X_W-1:0] frog_x,
    input  logic [Y_W-1:0] frog_y,
    input  logic [X_W-1:0] car_x,
    input  logic [Y_W-1:0] car_y,
    input  logic           car_en,
    output logic           hit
);

    localparam logic [X_W:0] FROG_W_X   = (X_W + 1)'(FROG_W);
    localparam logic [X_W:0] CAR_W_X    = (X_W + 1)'(CAR_W);
    localparam logic [X_W:0] SCREEN_W_X = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] FROG_W_Y   = (Y_W + 1)'(FROG_W);
    localparam logic [Y_W:0] TILE_Y     = (Y_W + 1)'(TILE_SIZE);

    logic [X_W:0] frog_x_ext_s;
    logic [X_W:0] frog_x_end_s;
    logic [X_W:0] car_x_ext_s;
    logic [X_W:0] car_x_end_s;
    logic [X_W:0] wrap_end_s;
    logic [Y_W:0] frog_y_end_s;
    logic [Y_W:0] car_y_end_s;
    logic         x_main_s;
    logic         x_wrap_s;
    logic         y_ov_s;

    // One extra bit on every sum so edge-of-screen positions never overflow.
    always_comb begin
        frog_x_ext_s = {1'b0, frog_x};
        car_x_ext_s  = {1'b0, car_x};
        frog_x_end_s = frog_x_ext_s + FROG_W_X;
        car_x_end_s  = car_x_ext_s + CAR_W_X;
        frog_y_end_s = {1'b0, frog_y} + FROG_W_Y;
        car_y_end_s  = {1'b0, car_y} + TILE_Y;
        wrap_end_s   = '0;
        x_wrap_s     = 1'b0;

        x_main_s = (frog_x_ext_s < car_x_end_s) && (car_x_ext_s < frog_x_end_s);
        y_ov_s   = ({1'b0, frog_y} < car_y_end_s) && ({1'b0, car_y} < frog_y_end_s);

        if ((WRAP_EN != 0) && (car_x_end_s > SCREEN_W_X)) begin
            wrap_end_s = car_x_end_s - SCREEN_W_X;
            x_wrap_s   = (frog_x_ext_s < wrap_end_s) && ((X_W + 1)'(0) < frog_x_end_s);
        end else begin
            wrap_end_s = '0;
            x_wrap_s   = 1'b0;
        end

        if (car_en) begin
            hit = y_ov_s && (x_main_s || x_wrap_s);
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/collision_scanner.sv
// Frame-rate collision scanner: snapshots frog and cars on i_Start, tests one car
// per clock, then publishes a held hit mask, any-hit flag and lowest hit index.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int NUM_CARS  = 8,
    parameter int FROG_W    = 32,
    parameter int CAR_W     = 32,
    parameter int TILE_SIZE = 32,
    parameter int SCREEN_W  = 640,
    parameter int WRAP_EN   = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_N,
    input  logic                    i_Start,
    input  logic [X_W-1:0]          i_Frog_X,
    input  logic [Y_W-1:0]          i_Frog_Y,
    input  logic [NUM_CARS*X_W-1:0] i_Car_X,
    input  logic [NUM_CARS*Y_W-1:0] i_Car_Y,
    input  logic [NUM_CARS-1:0]     i_Car_En,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic                    o_Has_Collided,
    output logic [NUM_CARS-1:0]     o_Hit_Mask,
    output logic [IDX_W-1:0]        o_Hit_Idx
);

    scan_state_e             state_r;
    scan_state_e             state_s;
    logic [IDX_W-1:0]        idx_r;
    logic [NUM_CARS-1:0]     mask_r;
    logic [NUM_CARS-1:0]     mask_next_s;
    logic [X_W-1:0]          frog_x_r;
    logic [Y_W-1:0]          frog_y_r;
    logic [NUM_CARS*X_W-1:0] car_x_r;
    logic [NUM_CARS*Y_W-1:0] car_y_r;
    logic [NUM_CARS-1:0]     car_en_r;
    logic [X_W-1:0]          sel_x_s;
    logic [Y_W-1:0]          sel_y_s;
    logic                    sel_en_s;
    logic                    hit_s;
    logic                    last_s;

    // Select the snapshot of the car under test and fold its result into the mask.
    always_comb begin
        sel_x_s     = '0;
        sel_y_s     = '0;
        sel_en_s    = 1'b0;
        mask_next_s = mask_r;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                sel_x_s        = car_x_r[k*X_W +: X_W];
                sel_y_s        = car_y_r[k*Y_W +: Y_W];
                sel_en_s       = car_en_r[k];
                mask_next_s[k] = mask_r[k] | hit_s;
            end else begin
                mask_next_s[k] = mask_r[k];
            end
        end
        last_s = (idx_r == IDX_W'(NUM_CARS - 1));
    end

    collision_overlap #(
        .FROG_W    (FROG_W),
        .CAR_W     (CAR_W),
        .TILE_SIZE (TILE_SIZE),
        .SCREEN_W  (SCREEN_W),
        .WRAP_EN   (WRAP_EN)
    ) u_overlap (
        .frog_x (frog_x_r),
        .frog_y (frog_y_r),
        .car_x  (sel_x_s),
        .car_y  (sel_y_s),
        .car_en (sel_en_s),
        .hit    (hit_s)
    );

    // Next-state logic; starts arriving while busy or in DONE are dropped.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_Start) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SCAN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Snapshot, scan accumulation and result publication; results land on the
    // edge into DONE so they are valid in the same cycle as o_Done.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            idx_r          <= '0;
            mask_r         <= '0;
            frog_x_r       <= '0;
            frog_y_r       <= '0;
            car_x_r        <= '0;
            car_y_r        <= '0;
            car_en_r       <= '0;
            o_Busy         <= 1'b0;
            o_Done         <= 1'b0;
            o_Has_Collided <= 1'b0;
            o_Hit_Mask     <= '0;
            o_Hit_Idx      <= '0;
        end else begin
            o_Done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_Start) begin
                        frog_x_r <= i_Frog_X;
                        frog_y_r <= i_Frog_Y;
                        car_x_r  <= i_Car_X;
                        car_y_r  <= i_Car_Y;
                        car_en_r <= i_Car_En;
                        mask_r   <= '0;
                        idx_r    <= '0;
                        o_Busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    mask_r <= mask_next_s;
                    idx_r  <= idx_r + 4'd1;
                    if (last_s) begin
                        o_Hit_Mask     <= mask_next_s;
                        o_Has_Collided <= |mask_next_s;
                        o_Hit_Idx      <= lowest_set_idx(16'(mask_next_s));
                        o_Done         <= 1'b1;
                        o_Busy         <= 1'b0;
                    end
                end
                DONE: begin
                    o_Busy <= 1'b0;
                end
                default: begin
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner: a wrapping and a non-wrapping instance
// share stimulus; expectations come from an integer geometry model.
module tb_collision_scanner;

    localparam int N = 8;

    logic            i_Clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [9:0]      frog_x;
    logic [8:0]      frog_y;
    logic [N*10-1:0] car_x;
    logic [N*9-1:0]  car_y;
    logic [N-1:0]    car_en;

    logic            busy, done, has;
    logic [N-1:0]    mask;
    logic [3:0]      idx;
    logic            busy_nw, done_nw, has_nw;
    logic [N-1:0]    mask_nw;
    logic [3:0]      idx_nw;

    typedef struct packed {
        logic [N-1:0] mask;
        logic         has;
        logic [3:0]   idx;
        logic [N-1:0] mask_nw;
        logic         has_nw;
        logic [3:0]   idx_nw;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 i_Clk = ~i_Clk;

    collision_scanner #(.NUM_CARS(N), .WRAP_EN(1)) dut (
        .i_Clk(i_Clk), .i_Rst_N(rst_n), .i_Start(start),
        .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Car_X(car_x), .i_Car_Y(car_y),
        .i_Car_En(car_en), .o_Busy(busy), .o_Done(done), .o_Has_Collided(has),
        .o_Hit_Mask(mask), .o_Hit_Idx(idx)
    );

    collision_scanner #(.NUM_CARS(N), .WRAP_EN(0)) dut_nw (
        .i_Clk(i_Clk), .i_Rst_N(rst_n), .i_Start(start),
        .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Car_X(car_x), .i_Car_Y(car_y),
        .i_Car_En(car_en), .o_Busy(busy_nw), .o_Done(done_nw), .o_Has_Collided(has_nw),
        .o_Hit_Mask(mask_nw), .o_Hit_Idx(idx_nw)
    );

    function automatic bit model_hit(input int fx, input int fy, input int cx,
                                     input int cy, input bit en, input bit wrap);
        bit ov_x, ov_y;
        if (!en) return 1'b0;
        ov_y = (fy < cy + 32) && (cy < fy + 32);
        ov_x = (fx < cx + 32) && (cx < fx + 32);
        if (wrap && (cx + 32 > 640)) ov_x = ov_x || (fx < cx + 32 - 640);
        return ov_x && ov_y;
    endfunction

    function automatic exp_t model_scan();
        exp_t e;
        bit   found, found_nw;
        int   cx, cy;
        e = '0;
        found = 1'b0;
        found_nw = 1'b0;
        for (int k = 0; k < N; k++) begin
            cx = int'(car_x[k*10 +: 10]);
            cy = int'(car_y[k*9 +: 9]);
            e.mask[k]    = model_hit(int'(frog_x), int'(frog_y), cx, cy, car_en[k], 1'b1);
            e.mask_nw[k] = model_hit(int'(frog_x), int'(frog_y), cx, cy, car_en[k], 1'b0);
            if (e.mask[k] && !found) begin e.idx = 4'(k); found = 1'b1; end
            if (e.mask_nw[k] && !found_nw) begin e.idx_nw = 4'(k); found_nw = 1'b1; end
        end
        e.has = found;
        e.has_nw = found_nw;
        return e;
    endfunction

    task automatic set_car(input int k, input int x, input int y, input bit en);
        car_x[k*10 +: 10] = 10'(x);
        car_y[k*9 +: 9]   = 9'(y);
        car_en[k]         = en;
    endtask

    task automatic clear_cars();
        car_x  = '0;
        car_y  = '0;
        car_en = '0;
    endtask

    // Start is raised on the negedge of cycle 0 and lowered on the negedge of cycle 1.
    task automatic pulse_start();
        @(negedge i_Clk) start = 1'b1;
        @(negedge i_Clk) start = 1'b0;
    endtask

    // Scoreboard monitor: every o_Done pops one expectation.
    always @(negedge i_Clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got o_Done=1 want no pending scan at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({has, mask, idx} !== {e.has, e.mask, e.idx}) begin
                    bad++;
                    $display("FAIL result_wrap: got has=%0b mask=%02h idx=%0d want has=%0b mask=%02h idx=%0d",
                             has, mask, idx, e.has, e.mask, e.idx);
                end
                total++;
                if ({done_nw, has_nw, mask_nw, idx_nw} !== {1'b1, e.has_nw, e.mask_nw, e.idx_nw}) begin
                    bad++;
                    $display("FAIL result_nowrap: got done=%0b has=%0b mask=%02h idx=%0d want done=1 has=%0b mask=%02h idx=%0d",
                             done_nw, has_nw, mask_nw, idx_nw, e.has_nw, e.mask_nw, e.idx_nw);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        frog_x = '0;
        frog_y = '0;
        clear_cars();
        repeat (2) @(negedge i_Clk);
        total++;
        if ({busy, done, has, mask, idx} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b has=%0b mask=%02h idx=%0d want all 0",
                     busy, done, has, mask, idx);
        end
        @(negedge i_Clk) rst_n = 1'b1;
        @(negedge i_Clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_single_hit();
        clear_cars();
        frog_x = 10'd100;
        frog_y = 9'd128;
        set_car(2, 110, 128, 1'b1);
        sb_q.push_back(model_scan());
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_cycle1: got %0b want 1", busy);
        end
        repeat (7) @(negedge i_Clk);
        total++;
        if (done !== 1'b0 || mask !== 8'h00) begin
            bad++;
            $display("FAIL early_done: got done=%0b mask=%02h want done=0 mask=00", done, mask);
        end
        @(negedge i_Clk);
        total++;
        if ({done, busy, has, mask, idx} !== {1'b1, 1'b0, 1'b1, 8'h04, 4'd2}) begin
            bad++;
            $display("FAIL single_hit_c9: got done=%0b busy=%0b has=%0b mask=%02h idx=%0d want 1 0 1 04 2",
                     done, busy, has, mask, idx);
        end
        @(negedge i_Clk);
        total++;
        if (done !== 1'b0 || mask !== 8'h04) begin
            bad++;
            $display("FAIL done_pulse_width: got done=%0b mask=%02h want done=0 mask=04", done, mask);
        end
    endtask

    task automatic test_reset_mid_scan();
        pulse_start();
        @(negedge i_Clk);
        @(negedge i_Clk) rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, has, mask, idx} !== '0) begin
            bad++;
            $display("FAIL mid_scan_reset: got busy=%0b done=%0b has=%0b mask=%02h idx=%0d want all 0",
                     busy, done, has, mask, idx);
        end
        repeat (3) @(negedge i_Clk);
        @(negedge i_Clk) rst_n = 1'b1;
        repeat (12) @(negedge i_Clk);
        total++;
        if (busy !== 1'b0 || has !== 1'b0) begin
            bad++;
            $display("FAIL after_mid_reset: got busy=%0b has=%0b want 0 0", busy, has);
        end
    endtask

    task automatic test_touching();
        clear_cars();
        frog_x = 10'd100;
        frog_y = 9'd128;
        set_car(0, 132, 128, 1'b1);
        set_car(1, 68, 128, 1'b1);
        sb_q.push_back(model_scan());
        pulse_start();
        repeat (8) @(negedge i_Clk);
        total++;
        if ({done, has, mask} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL touching: got done=%0b has=%0b mask=%02h want 1 0 00", done, has, mask);
        end
    endtask

    task automatic test_wrap();
        clear_cars();
        frog_x = 10'd0;
        frog_y = 9'd192;
        set_car(3, 620, 192, 1'b1);
        sb_q.push_back(model_scan());
        pulse_start();
        repeat (8) @(negedge i_Clk);
        total++;
        if ({done, mask, idx, mask_nw, has_nw} !== {1'b1, 8'h08, 4'd3, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL wrap: got done=%0b mask=%02h idx=%0d nw_mask=%02h nw_has=%0b want 1 08 3 00 0",
                     done, mask, idx, mask_nw, has_nw);
        end
    endtask

    task automatic test_two_hits_live_change();
        clear_cars();
        frog_x = 10'd300;
        frog_y = 9'd64;
        set_car(1, 290, 64, 1'b1);
        set_car(5, 320, 80, 1'b1);
        set_car(3, 500, 64, 1'b1);
        set_car(6, 300, 200, 1'b1);
        sb_q.push_back(model_scan());
        pulse_start();
        set_car(1, 400, 64, 1'b1);
        frog_x = 10'd600;
        repeat (4) @(negedge i_Clk);
        total++;
        if ({has, mask, idx} !== {1'b1, 8'h08, 4'd3}) begin
            bad++;
            $display("FAIL held_during_scan: got has=%0b mask=%02h idx=%0d want 1 08 3", has, mask, idx);
        end
        repeat (4) @(negedge i_Clk);
        total++;
        if ({done, mask, idx} !== {1'b1, 8'h22, 4'd1}) begin
            bad++;
            $display("FAIL two_hits: got done=%0b mask=%02h idx=%0d want 1 22 1", done, mask, idx);
        end
    endtask

    task automatic test_back_to_back();
        clear_cars();
        frog_x = 10'd200;
        frog_y = 9'd300;
        set_car(0, 210, 300, 1'b1);
        sb_q.push_back(model_scan());
        pulse_start();
        repeat (3) @(negedge i_Clk);
        start = 1'b1;
        set_car(4, 200, 300, 1'b1);
        @(negedge i_Clk) start = 1'b0;
        repeat (4) @(negedge i_Clk);
        total++;
        if ({done, mask} !== {1'b1, 8'h01}) begin
            bad++;
            $display("FAIL ignore_busy_start: got done=%0b mask=%02h want 1 01", done, mask);
        end
        start = 1'b1;
        @(negedge i_Clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle_start: got done=%0b busy=%0b want 0 0", done, busy);
        end
        sb_q.push_back(model_scan());
        @(negedge i_Clk) start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_busy: got busy=%0b want 1", busy);
        end
        repeat (7) @(negedge i_Clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL restart_early: got done=%0b at cycle 18 want 0", done);
        end
        @(negedge i_Clk);
        total++;
        if ({done, mask, idx} !== {1'b1, 8'h11, 4'd0}) begin
            bad++;
            $display("FAIL restart_c19: got done=%0b mask=%02h idx=%0d want 1 11 0", done, mask, idx);
        end
    endtask

    task automatic test_random();
        int y;
        for (int it = 0; it < 8; it++) begin
            clear_cars();
            frog_x = 10'($urandom_range(0, 639));
            frog_y = 9'($urandom_range(40, 440));
            for (int k = 0; k < N; k++) begin
                y = int'(frog_y) + int'($urandom_range(0, 80)) - 40;
                set_car(k, int'($urandom_range(0, 639)), y, 1'($urandom_range(0, 1)));
            end
            if (it % 2 == 0) begin
                frog_x = 10'($urandom_range(0, 20));
                set_car(it % N, int'($urandom_range(610, 639)), int'(frog_y), 1'b1);
            end
            sb_q.push_back(model_scan());
            pulse_start();
            repeat (8) @(negedge i_Clk);
            total++;
            if (done !== 1'b1) begin
                bad++;
                $display("FAIL random_latency[%0d]: got done=%0b want 1", it, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_reset_mid_scan();
        test_touching();
        test_wrap();
        test_two_hits_live_change();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge i_Clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Parametrised successor to the five-lane frog/car collision check.
- On each i_Start pulse (one per video frame) it snapshots the frog and all NUM_CARS car positions, then tests one car per clock against the frog.
- It reports a registered collision flag, a hit mask and the lowest colliding car index, and signals completion with o_Done.
- Upgrades over the previous check: full-box overlap on both axes, per-car lane Y, per-car enable, and horizontal screen wrap-around.

Parameters:
- NUM_CARS, 8, number of cars scanned (1..16)
- FROG_W, 32, frog width and height in pixels
- CAR_W, 32, car width in pixels; car height = TILE_SIZE
- TILE_SIZE, 32, car height in pixels
- SCREEN_W, 640, horizontal wrap modulus in pixels
- WRAP_EN, 1, 1 = a car extending past SCREEN_W also occupies [0, car_x+CAR_W-SCREEN_W)

Ports:
- i_Clk  in  1  system clock
- i_Rst_N  in  1  asynchronous active-low reset
- i_Start  in  1  single-cycle scan request
- i_Frog_X  in  10  frog top-left X
- i_Frog_Y  in  9  frog top-left Y
- i_Car_X  in  NUM_CARS*10  packed car X; car k at bits [10k+9:10k]
- i_Car_Y  in  NUM_CARS*9  packed lane Y; car k at bits [9k+8:9k]
- i_Car_En  in  NUM_CARS  per-car enable; 0 = never collides
- o_Busy  out  1  scan in progress
- o_Done  out  1  one-cycle pulse when the scan completes
- o_Has_Collided  out  1  any enabled car overlaps the frog (held until next o_Done)
- o_Hit_Mask  out  NUM_CARS  bit k = car k overlaps (held)
- o_Hit_Idx  out  4  lowest index k with a hit; 0 if none (held)

Behaviour:
- Clock and reset: single clock. i_Rst_N low asynchronously clears all state and outputs to 0 and forces state IDLE. Reset mid-scan discards the partial scan with no o_Done.
- IDLE:
  - i_Start=1 latches i_Frog_X/Y, i_Car_X/Y and i_Car_En into snapshot registers.
  - Clears the working mask and index counter, then goes to SCAN with o_Busy=1 from the next cycle.
- SCAN:
  - Each cycle evaluates car[idx] from the snapshot and ORs the result into bit idx of the working mask. idx increments.
  - After idx = NUM_CARS-1 is evaluated, goes to DONE.
- DONE (one cycle):
  - Copies the working mask to o_Hit_Mask.
  - Sets o_Has_Collided = |mask and o_Hit_Idx = lowest set bit (0 if none).
  - Pulses o_Done=1, drops o_Busy, returns to IDLE.
- Latency: i_Start sampled at cycle 0 gives o_Done at cycle NUM_CARS+1; results are valid in that same cycle.
- While busy, i_Start is ignored (no queueing). Changes to live inputs during a scan have no effect on the result.
- i_Start in the DONE cycle is ignored. i_Start on the cycle after o_Done is accepted. Back-to-back scans are therefore spaced NUM_CARS+2 cycles apart.
- Held outputs change only at o_Done; they keep their previous values throughout a scan.
- Overlap rule for a car with enable=1:
  - X and Y half-open intervals must intersect.
  - Y: frog_y < car_y+TILE_SIZE and car_y < frog_y+FROG_W.
  - X: frog_x < car_x+CAR_W and car_x < frog_x+FROG_W.
  - All sums use 11-bit (X) or 10-bit (Y) arithmetic, so there is no overflow wrap.
- Wrap (WRAP_EN=1 and car_x+CAR_W > SCREEN_W): additionally test X interval [0, car_x+CAR_W-SCREEN_W). A hit in either segment counts. With WRAP_EN=0 only the unwrapped interval is used.
- Touching edges (frog_x+FROG_W == car_x) is not a collision.
- Disabled car: mask bit forced 0 regardless of geometry.

Decomposition:
- collision_pkg:
  - X_W=10, Y_W=9 width constants
  - state enum {IDLE, SCAN, DONE}
  - IDX_W constant (4)
- Sub-module collision_overlap: purely combinational box-overlap test. Inputs are frog X/Y, car X/Y, enable, and the size/wrap parameters; output is 1-bit hit. Instantiated once and driven by the snapshot mux at idx.
- Top holds the FSM, snapshot registers, index counter, mask accumulation and priority encoder.

Test Plan:
- Reset held low mid-scan (i_Start at cycle 0, reset at cycle 3) -> all outputs 0, no o_Done; the next i_Start completes normally.
- Frog (100,128), car2 at (110,128), all other cars disabled, NUM_CARS=8 -> o_Done at cycle 9, o_Hit_Mask=8'b0000_0100, o_Hit_Idx=2, o_Has_Collided=1.
- Frog (100,128), car0 at (132,128) (touching edge), car1 at (68,128) (touching) -> mask 0, o_Has_Collided=0.
- WRAP_EN=1, car3 at (620,192), frog at (0,192) -> hit (wrapped segment [0,12)). Same case with WRAP_EN=0 -> no hit.
- Cars 1 and 5 both overlap the frog -> o_Hit_Mask=8'b0010_0010, o_Hit_Idx=1. Moving car1 away during the scan (after i_Start) does not change the result.
- i_Start pulsed at cycles 0, 4 and 9 -> the cycle-4 pulse is ignored, the cycle-9 pulse (the DONE cycle) is ignored, and an i_Start at cycle 10 starts a new scan with o_Done at cycle 19.
